frame_load_ctrl: RTL and testbench
==================================

Name: frame_load_ctrl

Overview:
- Sequences one inference per frame: accepts a HEIGHTxWIDTHxDEPTH byte stream from the Raspberry Pi over gpio_pin/write_enable, drives the image-buffer write port, starts the neural-net core, and latches its class result onto LED.
- Sits between the Pi GPIO pins and the image buffer plus inference core. Replaces ad-hoc counting inside the buffer with a single owner of frame addressing and handshake.

Parameters:
- HEIGHT, 20, image rows
- WIDTH, 30, image columns
- DEPTH, 3, channels per pixel (HSV)
- TIMEOUT_CYCLES, 1000000, max idle pi_clk cycles between bytes during LOAD before abort
- CLASS_W, 6, width of class result and LED bus

Ports:
- pi_clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- gpio_pin  in  8  pixel byte from Pi, stable while write_enable high
- write_enable  in  1  byte strobe from Pi, asynchronous to pi_clk
- mem_we  out  1  image buffer write strobe, one cycle per byte
- mem_addr  out  11  linear address ((h*WIDTH)+w)*DEPTH+d
- mem_wdata  out  8  byte to write
- nn_start  out  1  one-cycle pulse to start inference
- nn_done  in  1  one-cycle pulse from core, result valid
- nn_class  in  CLASS_W  class index, valid with nn_done
- pi_ready  out  1  high when block accepts bytes (IDLE or LOAD)
- frame_err  out  1  sticky timeout flag, cleared at next frame's first byte
- LED  out  CLASS_W  last latched class

Behaviour:
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, nn_start=0, pi_ready=1, frame_err=0, LED=0, state=IDLE, all counters 0, sync flops 0.
- Input sync: write_enable passes through 2-FF synchronizer s1,s2, then delay s3. Byte event = s2 & ~s3.
- On a byte event, gpio_pin is captured into mem_wdata and mem_we pulses high for exactly one cycle in the following cycle.
- Latency: first pi_clk edge sampling write_enable=1 -> mem_we high 3 cycles later.
- A strobe held high for many cycles produces exactly one write.
- Counters d, w, h are kept separately and mem_addr is registered from them. Width rule: NBYTES=HEIGHT*WIDTH*DEPTH=1800 fits 11 bits.
  - d wraps at DEPTH-1 -> 0 with w++.
  - w wraps at WIDTH-1 -> 0 with h++.
- States:
  - IDLE: first byte event -> LOAD. That byte is written to addr 0 and frame_err is cleared.
  - LOAD: each byte event writes and advances the counters. The write of byte index NBYTES-1 (addr 1799) -> RUN next cycle, and nn_start pulses on RUN entry.
  - LOAD timeout: an idle counter resets on each byte event. When it reaches TIMEOUT_CYCLES -> IDLE with frame_err=1 and counters=0. No nn_start is issued.
  - RUN: pi_ready=0 and byte events are ignored (no mem_we). nn_done -> DONE, with LED<=nn_class on that edge.
  - DONE: one cycle, counters cleared, -> IDLE with pi_ready=1.
- nn_done outside RUN is ignored; LED is unchanged.
- A byte event coincident with the timeout terminal count: the byte wins, the idle counter resets and state stays in LOAD.
- Reset mid-LOAD or mid-RUN: everything returns to reset values immediately. LED clears to 0. A later nn_done is ignored because the state is IDLE.
- nn_start never re-pulses within one RUN.

Decomposition:
- Shared package nn_pkg:
  - HEIGHT/WIDTH/DEPTH defaults
  - NBYTES and ADDR_W = $clog2(NBYTES)
  - CLASS_W
  - state enum typedef ctrl_state_t {IDLE, LOAD, RUN, DONE}
- One sub-module, strobe_sync: 2-FF synchronizer plus rising-edge detector, output one-cycle byte_evt. It is reused for any future Pi control line.

Test Plan:
- Full frame: reset, send 1800 bytes with value i%256, 10-cycle high / 10-cycle low strobe. Expect 1800 mem_we pulses with addr 0..1799 and wdata=i%256, byte 90 at addr 90, then one nn_start.
- Result latch: after nn_start, drive nn_done with nn_class=6'd37 50 cycles later. Expect LED=37 next cycle, pi_ready back to 1 after DONE, and 0 extra mem_we.
- Held strobe: hold write_enable high for 40 cycles on one byte. Expect exactly one mem_we, 3 cycles after the first sample.
- Timeout: with TIMEOUT_CYCLES=100, send 500 bytes then stop. Expect return to IDLE at cycle 100 after the last event, frame_err=1 and no nn_start. The next byte writes addr 0 and clears frame_err.
- Busy reject: pulse write_enable 5 times during RUN. Expect no mem_we and pi_ready=0. nn_done pulsed in IDLE leaves LED unchanged.
- Reset mid-frame: assert rst after 1000 bytes. Expect all outputs at reset values immediately, and the next frame to start at addr 0 and complete normally.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared constants and types for the Pi frame loader and inference sequencing.
package nn_pkg;

  localparam int HEIGHT_DEF  = 20;
  localparam int WIDTH_DEF   = 30;
  localparam int DEPTH_DEF   = 3;
  localparam int TIMEOUT_DEF = 1000000;
  localparam int CLASS_W     = 6;

  localparam int NBYTES = HEIGHT_DEF * WIDTH_DEF * DEPTH_DEF;
  localparam int ADDR_W = $clog2(NBYTES);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } ctrl_state_t;

endpackage

// File: rtl/frame_load_ctrl_strobe_sync.sv
// Two-flop synchronizer plus rising-edge detector for an asynchronous Pi strobe.
module strobe_sync (
  input  logic clk,
  input  logic rst,
  input  logic strobe_in,
  output logic byte_evt
);

  logic s1_q, s2_q, s3_q, evt_q;
  logic s1_d, s2_d, s3_d, evt_d;

  always_comb begin
    s1_d  = strobe_in;
    s2_d  = s1_q;
    s3_d  = s2_q;
    // Registered edge so the event lands in a clean cycle of its own.
    evt_d = s2_q & ~s3_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      s3_q  <= 1'b0;
      evt_q <= 1'b0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      s3_q  <= s3_d;
      evt_q <= evt_d;
    end
  end

  assign byte_evt = evt_q;

endmodule

// File: rtl/frame_load_ctrl.sv
// Owns frame addressing for the Pi byte stream, starts the inference core and
// latches its class result onto the LEDs.
module frame_load_ctrl
  import nn_pkg::*;
#(
  parameter int HEIGHT         = HEIGHT_DEF,
  parameter int WIDTH          = WIDTH_DEF,
  parameter int DEPTH          = DEPTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic               pi_clk,
  input  logic               rst,
  input  logic [7:0]         gpio_pin,
  input  logic               write_enable,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [7:0]         mem_wdata,
  output logic               nn_start,
  input  logic               nn_done,
  input  logic [CLASS_W-1:0] nn_class,
  output logic               pi_ready,
  output logic               frame_err,
  output logic [CLASS_W-1:0] LED
);

  localparam int CNT_W  = ADDR_W;
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0]  D_LAST    = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  W_LAST    = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  H_LAST    = CNT_W'(HEIGHT - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  ctrl_state_t state_q, state_d;
  logic [CNT_W-1:0]   d_q, d_d, w_q, w_d, h_q, h_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [7:0]         mem_wdata_q, mem_wdata_d;
  logic               nn_start_q, nn_start_d;
  logic               frame_err_q, frame_err_d;
  logic [CLASS_W-1:0] led_q, led_d;
  logic               byte_evt;
  logic               accept;
  logic               last_byte;

  strobe_sync u_we_sync (
    .clk      (pi_clk),
    .rst      (rst),
    .strobe_in(write_enable),
    .byte_evt (byte_evt)
  );

  always_comb begin
    state_d     = state_q;
    d_d         = d_q;
    w_d         = w_q;
    h_d         = h_q;
    idle_d      = idle_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    nn_start_d  = 1'b0;
    frame_err_d = frame_err_q;
    led_d       = led_q;

    accept    = byte_evt && ((state_q == IDLE) || (state_q == LOAD));
    last_byte = (d_q == D_LAST) && (w_q == W_LAST) && (h_q == H_LAST);

    // Write and counter advance are shared by IDLE (first byte) and LOAD.
    if (accept) begin
      mem_we_d    = 1'b1;
      mem_wdata_d = gpio_pin;
      mem_addr_d  = ADDR_W'((int'(h_q) * WIDTH + int'(w_q)) * DEPTH + int'(d_q));
      idle_d      = '0;
      if (d_q == D_LAST) begin
        d_d = '0;
        if (w_q == W_LAST) begin
          w_d = '0;
          h_d = h_q + 1'b1;
        end else begin
          w_d = w_q + 1'b1;
        end
      end else begin
        d_d = d_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          frame_err_d = 1'b0;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          if (last_byte) begin
            state_d    = RUN;
            nn_start_d = 1'b1;
          end
        end else if (idle_q == IDLE_LAST) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
          d_d         = '0;
          w_d         = '0;
          h_d         = '0;
          idle_d      = '0;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      RUN: begin
        if (nn_done) begin
          led_d   = nn_class;
          state_d = DONE;
        end
      end
      DONE: begin
        d_d     = '0;
        w_d     = '0;
        h_d     = '0;
        idle_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pi_clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      d_q         <= '0;
      w_q         <= '0;
      h_q         <= '0;
      idle_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      nn_start_q  <= 1'b0;
      frame_err_q <= 1'b0;
      led_q       <= '0;
    end else begin
      state_q     <= state_d;
      d_q         <= d_d;
      w_q         <= w_d;
      h_q         <= h_d;
      idle_q      <= idle_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      nn_start_q  <= nn_start_d;
      frame_err_q <= frame_err_d;
      led_q       <= led_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign nn_start  = nn_start_q;
  assign frame_err = frame_err_q;
  assign LED       = led_q;
  assign pi_ready  = (state_q == IDLE) || (state_q == LOAD);

endmodule

// File: tb/tb_frame_load_ctrl.sv
// Scoreboard bench: stimulus pushes expected writes, a negedge monitor pops and compares.
module tb_frame_load_ctrl;

  localparam int NB = nn_pkg::NBYTES;
  localparam int TO = 100;

  logic        pi_clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  gpio_pin = '0;
  logic        write_enable = 1'b0;
  logic        mem_we;
  logic [10:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        nn_start;
  logic        nn_done = 1'b0;
  logic [5:0]  nn_class = '0;
  logic        pi_ready;
  logic        frame_err;
  logic [5:0]  LED;

  frame_load_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .pi_clk      (pi_clk),
    .rst         (rst),
    .gpio_pin    (gpio_pin),
    .write_enable(write_enable),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .nn_start    (nn_start),
    .nn_done     (nn_done),
    .nn_class    (nn_class),
    .pi_ready    (pi_ready),
    .frame_err   (frame_err),
    .LED         (LED)
  );

  always #5 pi_clk = ~pi_clk;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;
  int  wr_cnt = 0;
  int  start_cnt = 0;
  int  start_cyc = 0;
  int  last_we_cyc = 0;
  int  ferr_rise_cyc = -1;
  logic ferr_prev = 1'b0;

  // Reference model: linear frame index, busy while the core runs.
  int  model_idx = 0;
  bit  model_busy = 1'b0;
  int  exp_starts = 0;
  int  exp_wr_total = 0;

  function automatic void check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endfunction

  function automatic void model_accept(input logic [7:0] v);
    int h, w, d;
    if (!model_busy) begin
      h = model_idx / (nn_pkg::WIDTH_DEF * nn_pkg::DEPTH_DEF);
      w = (model_idx / nn_pkg::DEPTH_DEF) % nn_pkg::WIDTH_DEF;
      d = model_idx % nn_pkg::DEPTH_DEF;
      exp_q.push_back('{(h * nn_pkg::WIDTH_DEF + w) * nn_pkg::DEPTH_DEF + d, int'(v)});
      exp_wr_total++;
      model_idx++;
      if (model_idx == NB) begin
        model_idx  = 0;
        model_busy = 1'b1;
        exp_starts++;
      end
    end
  endfunction

  always @(negedge pi_clk) begin
    cyc++;
    if (!rst) begin
      if (mem_we) begin
        wr_cnt++;
        last_we_cyc = cyc;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got addr %0d data %0d required no write", mem_addr, mem_wdata);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", int'(mem_addr), e.addr);
          check("wr_data", int'(mem_wdata), e.data);
        end
      end
      if (nn_start) begin
        start_cnt++;
        start_cyc = cyc;
      end
      if (frame_err && !ferr_prev) ferr_rise_cyc = cyc;
    end
    ferr_prev = frame_err;
  end

  task automatic send_byte(input logic [7:0] v, input int hi, input int lo);
    model_accept(v);
    gpio_pin     = v;
    write_enable = 1'b1;
    repeat (hi) @(negedge pi_clk);
    write_enable = 1'b0;
    repeat (lo) @(negedge pi_clk);
  endtask

  task automatic send_rand(input int n);
    for (int i = 0; i < n; i++)
      send_byte(8'($urandom), int'($urandom_range(2, 4)), int'($urandom_range(3, 5)));
  endtask

  task automatic wait_start(input int target);
    int k;
    k = 0;
    while (start_cnt < target && k < 2000) begin
      @(negedge pi_clk);
      k++;
    end
    check("nn_start_count", start_cnt, exp_starts);
  endtask

  task automatic finish_inference(input logic [5:0] cls);
    while (cyc < start_cyc + 50) @(negedge pi_clk);
    nn_done  = 1'b1;
    nn_class = cls;
    @(posedge pi_clk);
    #1;
    nn_done = 1'b0;
    check("led_latch", int'(LED), int'(cls));
    check("pi_ready_done", int'(pi_ready), 0);
    @(posedge pi_clk);
    #1;
    check("pi_ready_back", int'(pi_ready), 1);
    model_busy = 1'b0;
    @(negedge pi_clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_mem_we"}, int'(mem_we), 0);
    check({tag, "_mem_addr"}, int'(mem_addr), 0);
    check({tag, "_mem_wdata"}, int'(mem_wdata), 0);
    check({tag, "_nn_start"}, int'(nn_start), 0);
    check({tag, "_pi_ready"}, int'(pi_ready), 1);
    check({tag, "_frame_err"}, int'(frame_err), 0);
    check({tag, "_led"}, int'(LED), 0);
  endtask

  initial begin
    int wr_before, k;
    logic [7:0] v;

    #1;
    check_reset_vals("reset");
    repeat (3) @(negedge pi_clk);
    rst = 1'b0;
    @(negedge pi_clk);

    // Full frame, slow 10/10 strobe, value i%256.
    for (int i = 0; i < NB; i++) send_byte(8'(i % 256), 10, 10);
    wait_start(1);
    check("pi_ready_run", int'(pi_ready), 0);

    // Strobes while the core runs must be dropped.
    wr_before = wr_cnt;
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 3, 3);
    repeat (4) @(negedge pi_clk);
    check("busy_no_write", wr_cnt - wr_before, 0);
    check("busy_pi_ready", int'(pi_ready), 0);
    finish_inference(6'd37);
    check("start_once", start_cnt, 1);

    // nn_done while idle leaves LED alone.
    nn_done  = 1'b1;
    nn_class = 6'd12;
    @(negedge pi_clk);
    nn_done = 1'b0;
    repeat (2) @(negedge pi_clk);
    check("idle_done_led", int'(LED), 37);

    // Held strobe: one write, three edges after first sample.
    wr_before = wr_cnt;
    v = 8'($urandom);
    model_accept(v);
    gpio_pin     = v;
    write_enable = 1'b1;
    for (int e = 0; e < 4; e++) begin
      @(posedge pi_clk);
      #1;
      check("held_latency", int'(mem_we), (e == 3) ? 1 : 0);
    end
    repeat (36) @(negedge pi_clk);
    write_enable = 1'b0;
    repeat (4) @(negedge pi_clk);
    check("held_one_write", wr_cnt - wr_before, 1);

    // Timeout after 500 bytes in the frame.
    send_rand(499);
    k = 0;
    while (ferr_rise_cyc < 0 && k < 300) begin
      @(negedge pi_clk);
      k++;
    end
    check("timeout_delay", ferr_rise_cyc - last_we_cyc, TO);
    check("timeout_ferr", int'(frame_err), 1);
    check("timeout_pi_ready", int'(pi_ready), 1);
    check("timeout_no_start", start_cnt, exp_starts);
    model_idx = 0;
    send_byte(8'($urandom), 3, 3);
    check("ferr_cleared", int'(frame_err), 0);

    // Reset in the middle of the frame (1000 bytes in).
    send_rand(999);
    repeat (3) @(negedge pi_clk);
    check("pre_reset_drained", exp_q.size(), 0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    model_idx  = 0;
    model_busy = 1'b0;
    repeat (3) @(negedge pi_clk);
    rst = 1'b0;
    @(negedge pi_clk);
    nn_done  = 1'b1;
    nn_class = 6'd5;
    @(negedge pi_clk);
    nn_done = 1'b0;
    @(negedge pi_clk);
    check("post_reset_done_ignored", int'(LED), 0);

    // Fresh frame after reset completes normally.
    send_rand(NB);
    wait_start(exp_starts);
    finish_inference(6'($urandom));

    check("queue_empty", exp_q.size(), 0);
    check("write_total", wr_cnt, exp_wr_total);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
